// File: rtl/adc_trig_seq_pkg.sv
// Shared definitions for the ADC trigger sequencer and its capture buffer.
package adc_trig_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        FIRE,
        WIN,
        GAP
    } state_e;

    // log2 of samples carried per PHY valid word; the capture buffer uses the same value
    localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/adc_trig_cnt.sv
// Loadable saturating down-counter with zero flag; serves the delay/gap waits
// and the capture-window word count.
module adc_trig_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/adc_trig_seq.sv
// Trigger sequencer: turns one start pulse into a burst of single-cycle capture
// triggers with start delay, per-capture window and inter-capture gap.
module adc_trig_seq
    import adc_trig_seq_pkg::*;
#(
    parameter int AW     = 12,
    parameter int DW_CNT = 16,
    parameter int NW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DW_CNT-1:0] delay,
    input  logic [DW_CNT-1:0] gap,
    input  logic [NW-1:0]     n_cap,
    input  logic [AW-1:0]     wfm_len_in,
    input  logic              adc_phy_val,
    output logic              adc_trigger,
    output logic [AW-1:0]     wfm_len,
    output logic              busy,
    output logic              done,
    output logic [NW-1:0]     cap_idx,
    output logic              err_len,
    output logic              err_ovr,
    input  logic              err_clr
);

    localparam int WW = AW - WORD_SHIFT;

    state_e            state_d, state_q;
    logic              trig_d, trig_q;
    logic              done_d, done_q;
    logic              busy_d, busy_q;
    logic [NW-1:0]     cap_idx_d, cap_idx_q;
    logic [NW-1:0]     n_last_d, n_last_q;
    logic [AW-1:0]     wfm_len_d, wfm_len_q;
    logic [DW_CNT-1:0] gap_d, gap_q;
    logic              err_len_d, err_len_q;
    logic              err_ovr_d, err_ovr_q;

    logic              cnt_load, cnt_dec, cnt_zero, win_end;
    logic [DW_CNT-1:0] cnt_val, cnt;
    logic [WW-1:0]     words_in, words_lat;

    assign words_in  = wfm_len_in[AW-1:WORD_SHIFT];
    assign words_lat = wfm_len_q[AW-1:WORD_SHIFT];

    // A zero count in WIN means the only word arrived on the FIRE cycle.
    assign win_end = cnt_zero || (adc_phy_val && (cnt == DW_CNT'(1)));

    adc_trig_cnt #(.W(DW_CNT)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        trig_d    = 1'b0;
        done_d    = 1'b0;
        cap_idx_d = cap_idx_q;
        n_last_d  = n_last_q;
        wfm_len_d = wfm_len_q;
        gap_d     = gap_q;
        err_len_d = err_len_q & ~err_clr;
        err_ovr_d = err_ovr_q & ~err_clr;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;

        if (abort) begin
            state_d   = IDLE;
            cap_idx_d = '0;
        end else begin
            if (start && (state_q != IDLE)) begin
                err_ovr_d = 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (words_in == '0) begin
                            err_len_d = 1'b1;
                        end else begin
                            wfm_len_d = wfm_len_in;
                            n_last_d  = (n_cap == '0) ? '0 : n_cap - NW'(1);
                            gap_d     = gap;
                            cap_idx_d = '0;
                            cnt_load  = 1'b1;
                            if (delay == '0) begin
                                state_d = FIRE;
                                trig_d  = 1'b1;
                                cnt_val = DW_CNT'(words_in);
                            end else begin
                                state_d = DELAY;
                                cnt_val = delay - DW_CNT'(1);
                            end
                        end
                    end
                end
                DELAY, GAP: begin
                    if (cnt_zero) begin
                        state_d  = FIRE;
                        trig_d   = 1'b1;
                        cnt_load = 1'b1;
                        cnt_val  = DW_CNT'(words_lat);
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                FIRE: begin
                    state_d = WIN;
                    cnt_dec = adc_phy_val;
                end
                WIN: begin
                    if (!win_end) begin
                        cnt_dec = adc_phy_val;
                    end else if (cap_idx_q == n_last_q) begin
                        state_d   = IDLE;
                        done_d    = 1'b1;
                        cap_idx_d = '0;
                    end else begin
                        cap_idx_d = cap_idx_q + NW'(1);
                        cnt_load  = 1'b1;
                        if (gap_q == '0) begin
                            state_d = FIRE;
                            trig_d  = 1'b1;
                            cnt_val = DW_CNT'(words_lat);
                        end else begin
                            state_d = GAP;
                            cnt_val = gap_q - DW_CNT'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // busy covers the done cycle so it falls one cycle after the pulse
        busy_d = (state_d != IDLE) || done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            trig_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            cap_idx_q <= '0;
            n_last_q  <= '0;
            wfm_len_q <= '0;
            gap_q     <= '0;
            err_len_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            trig_q    <= trig_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            cap_idx_q <= cap_idx_d;
            n_last_q  <= n_last_d;
            wfm_len_q <= wfm_len_d;
            gap_q     <= gap_d;
            err_len_q <= err_len_d;
            err_ovr_q <= err_ovr_d;
        end
    end

    assign adc_trigger = trig_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign cap_idx     = cap_idx_q;
    assign wfm_len     = wfm_len_q;
    assign err_len     = err_len_q;
    assign err_ovr     = err_ovr_q;

endmodule

// File: doc/adc_trig_seq.md
Name: adc_trig_seq

Overview:
- Trigger sequencer directly upstream of the ADC capture buffer, in the ADC PHY clock domain.
- Converts a single start pulse into a programmed burst of single-cycle capture triggers.
- Provides a configurable start delay, a per-capture window length and an inter-capture gap.
- Guarantees no trigger fires while the buffer is still writing the previous waveform.
- Drives the buffer's trigger and waveform-length inputs, and reports busy/done/error to the control logic.

Parameters:
AW, 12, waveform length width in samples; matches buffer address width
DW_CNT, 16, width of the delay and gap counters
NW, 8, width of the capture-count register

Ports:
clk  in  1  ADC PHY clock; sole clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a burst
abort  in  1  single-cycle; return to IDLE immediately
delay  in  DW_CNT  cycles from start to first trigger
gap  in  DW_CNT  idle cycles between end of window and next trigger
n_cap  in  NW  captures per burst; 0 means 1
wfm_len_in  in  AW  waveform length in samples
adc_phy_val  in  1  PHY data valid; each valid cycle carries 4 samples
adc_trigger  out  1  single-cycle trigger to capture buffer
wfm_len  out  AW  waveform length latched at start; held stable for the whole burst
busy  out  1  high from the cycle after start is accepted until return to IDLE
done  out  1  single-cycle pulse when the last window completes
cap_idx  out  NW  index of the current capture, 0-based
err_len  out  1  sticky; start rejected because wfm_len_in[AW-1:2]==0
err_ovr  out  1  sticky; start received while busy
err_clr  in  1  clears both sticky error flags

Behaviour:
- Reset values: adc_trigger=0, busy=0, done=0, cap_idx=0, wfm_len=0, err_len=0, err_ovr=0, state=IDLE, all counters 0.
- States:
  - IDLE: wait for start.
  - DELAY: load counter with `delay`, count down.
  - FIRE: single cycle; assert adc_trigger.
  - WIN: count valid words of the capture window.
  - GAP: load counter with `gap`, count down.
- IDLE + start, with wfm_len_in[AW-1:2]!=0:
  - latch wfm_len, n_cap (0 becomes 1), delay and gap.
  - go to DELAY; busy=1 next cycle.
- IDLE + start, with wfm_len_in[AW-1:2]==0: stay in IDLE, set err_len.
- Trigger timing: start accepted at cycle t gives adc_trigger high at cycle t+1+delay. delay=0 gives trigger at t+1.
- FIRE always lasts exactly 1 cycle. adc_trigger is registered and is never high for 2 consecutive cycles.
- WIN: counts adc_phy_val cycles. Leaves when count reaches wfm_len[AW-1:2], i.e. one buffer word = 4 samples.
  - The count includes a valid on the FIRE cycle.
  - Cycles without valid extend the window.
- End of window, last capture (cap_idx==n_cap-1): pulse done in the same cycle as the WIN exit, go to IDLE, busy drops next cycle.
- End of window, otherwise: cap_idx increments and state goes to GAP.
  - GAP lasts `gap` cycles, then FIRE. gap=0 goes straight to FIRE next cycle.
- wfm_len, delay, gap and n_cap are latched per burst. Input changes mid-burst are ignored.
- start while busy: ignored and sets err_ovr. Does not restart the burst.
- abort: in any state, next state is IDLE with no trigger, done not pulsed, cap_idx=0.
  - abort in the same cycle as start from IDLE: abort wins, nothing is latched.
- err_clr and a new error in the same cycle: the error flag stays set.
- rst mid-burst: all outputs return to their reset values the next cycle, and no pending trigger is issued.
- Counter width rules:
  - Counters are unsigned and never wrap. A counter at 0 does not decrement.
  - cap_idx compares against the latched n_cap-1 in NW bits.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE, DELAY, FIRE, WIN, GAP);
  - WORD_SHIFT=2 (samples per PHY word, log2), which is shared with the capture buffer.
- One natural sub-module, adc_trig_cnt: loadable down-counter with zero flag. It is instantiated for DELAY/GAP and reused for the WIN word count.

Test Plan:
- delay=5, gap=0, n_cap=1, wfm_len_in=16, adc_phy_val always 1, start at cycle 10 -> adc_trigger only at cycle 16; done at cycle 20; busy high cycles 11-20.
- n_cap=3, gap=2, delay=0, wfm_len_in=8, valid always 1 -> triggers at start+1, +5, +9; cap_idx steps 0,1,2; a single done pulse.
- adc_phy_val toggling 1,0 with wfm_len_in=8 -> window lasts 4 cycles; next trigger delayed accordingly.
- wfm_len_in=3 plus start -> no trigger, err_len=1, busy stays 0; err_clr -> err_len=0.
- start again during WIN -> err_ovr=1, burst timing unchanged; abort during GAP -> IDLE next cycle, no further trigger, no done.
- rst asserted during DELAY -> all outputs 0 next cycle; trigger never fires; next start behaves as fresh.
